// File: rtl/gpu_pkg.sv
// Shared types for the frame reader: FSM states, SDRAM address width, pixel layout.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package gpu_pkg;

   localparam int SD_ADDR_W           = 26;
   localparam int FRAME_WORDS_640x480 = 307200;
   localparam int CNT_W               = 19;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Fields declared MSB first, so r lands in bits [7:0] exactly as in the SDRAM word.
   typedef struct packed {
      logic [7:0] b;
      logic [7:0] g;
      logic [7:0] r;
   } pixel_t;

   // Word layout: [7:0]=r, [15:8]=g, [23:16]=b; the top byte carries nothing.
   function automatic pixel_t unpack_word(input logic [23:0] w);
      unpack_word = pixel_t'(w);
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO for unpacked pixels; head entry is read straight from storage flops.
// Latency: a word pushed at edge M is visible on o_dat with o_empty low from cycle M+1.
// Backpressure: push while full is refused unless a pop happens the same cycle.
// Ports: clk/n_rst, i_push/i_push_dat, i_pop, o_dat (head), o_full, o_empty, o_count.
module pixel_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_dat,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dat,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dat   = r_mem[r_rd_ptr];

   // When full, a same-cycle pop frees the slot being written, so the push is kept.
   assign w_do_push = i_push & (~o_full | i_pop);
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

endmodule

// File: rtl/sdram_frame_reader.sv
// Avalon-MM read master fetching one frame of 32-bit words and streaming r/g/b pixels.
// Latency: SD_read one cycle after frame_ready; a returned word is a pixel one cycle later.
// Backpressure: reads issued only while pending+buffered < FIFO_DEPTH; pix_ready stalls pops.
// Ports: clk, n_rst, frame_ready; Avalon SD_read/SD_address/waitrequest/SD_rdata/
//   SD_readdatavalid; pixel stream pix_r/g/b, pix_valid, pix_ready; status busy,
//   frame_done (pulse), overflow_err (sticky).
// Build option: FRAME_READER_LOOP_EN restarts the next frame automatically after DRAIN.
module sdram_frame_reader
   import gpu_pkg::*;
#(
   parameter logic [SD_ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                   FRAME_WORDS = FRAME_WORDS_640x480,
   parameter int                   FIFO_DEPTH  = 16
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 frame_ready,
   output logic                 SD_read,
   output logic [SD_ADDR_W-1:0] SD_address,
   input  logic                 waitrequest,
   input  logic [31:0]          SD_rdata,
   input  logic                 SD_readdatavalid,
   output logic [7:0]           pix_r,
   output logic [7:0]           pix_g,
   output logic [7:0]           pix_b,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 overflow_err
);

   localparam int               PW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(FRAME_WORDS);
   localparam logic [PW:0]      LP_DEPTH = (PW+1)'(FIFO_DEPTH);

   state_t               r_state, w_state_nxt;
   logic [SD_ADDR_W-1:0] r_addr, w_addr_nxt;
   logic [CNT_W-1:0]     r_issued, w_issued_nxt;
   logic [CNT_W-1:0]     r_returned, w_returned_nxt;
   logic [PW-1:0]        r_pending, w_pending_nxt;
   logic                 r_frame_done, w_frame_done_nxt;
   logic                 r_overflow;

   logic                 w_credit;
   logic                 w_accept;
   logic                 w_ret;
   logic                 w_pop;
   logic                 w_drain_done;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [PW-1:0]        w_fifo_count;
   pixel_t               w_fifo_dat;
   logic                 w_unused_msb;

   assign w_unused_msb = ^SD_rdata[31:24];

   // Reserve a FIFO slot for every outstanding read so returns always fit.
   assign w_credit = ({1'b0, r_pending} + {1'b0, w_fifo_count}) < LP_DEPTH;
   assign SD_read  = (r_state == FETCH) && w_credit && (r_issued != LP_LAST);
   assign w_accept = SD_read & ~waitrequest;

   // A return with nothing outstanding belongs to a request from before a reset.
   assign w_ret = SD_readdatavalid & (r_pending != '0);
   assign w_pop = pix_valid & pix_ready;

   // Finish on the edge of the last pop so frame_done and busy=0 appear together.
   assign w_drain_done = (r_pending == '0) && (r_returned >= LP_LAST) &&
                         (w_fifo_empty || ((w_fifo_count == PW'(1)) && w_pop));

   pixel_fifo #(
      .WIDTH (24),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .n_rst      (n_rst),
      .i_push     (w_ret),
      .i_push_dat (unpack_word(SD_rdata[23:0])),
      .i_pop      (w_pop),
      .o_dat      (w_fifo_dat),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty),
      .o_count    (w_fifo_count)
   );

   always_comb begin
      w_state_nxt      = r_state;
      w_addr_nxt       = r_addr;
      w_issued_nxt     = r_issued;
      w_returned_nxt   = r_returned + CNT_W'(w_ret);
      w_pending_nxt    = r_pending + PW'(w_accept) - PW'(w_ret);
      w_frame_done_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (frame_ready) begin
               w_state_nxt    = FETCH;
               w_addr_nxt     = BASE_ADDR;
               w_issued_nxt   = '0;
               w_returned_nxt = '0;
            end
         end
         FETCH: begin
            if (w_accept) begin
               w_addr_nxt   = r_addr + SD_ADDR_W'(4);
               w_issued_nxt = r_issued + CNT_W'(1);
               if ((r_issued + CNT_W'(1)) == LP_LAST) begin
                  w_state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (w_drain_done) begin
               w_frame_done_nxt = 1'b1;
`ifdef FRAME_READER_LOOP_EN
               w_state_nxt    = FETCH;
               w_addr_nxt     = BASE_ADDR;
               w_issued_nxt   = '0;
               w_returned_nxt = '0;
`else
               w_state_nxt    = IDLE;
`endif
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state      <= IDLE;
         r_addr       <= BASE_ADDR;
         r_issued     <= '0;
         r_returned   <= '0;
         r_pending    <= '0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_addr       <= w_addr_nxt;
         r_issued     <= w_issued_nxt;
         r_returned   <= w_returned_nxt;
         r_pending    <= w_pending_nxt;
         r_frame_done <= w_frame_done_nxt;
         if (w_ret && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign SD_address   = r_addr;
   assign pix_valid    = ~w_fifo_empty;
   assign pix_r        = w_fifo_dat.r;
   assign pix_g        = w_fifo_dat.g;
   assign pix_b        = w_fifo_dat.b;
   assign busy         = (r_state != IDLE);
   assign frame_done   = r_frame_done;
   assign overflow_err = r_overflow;

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Bench for sdram_frame_reader: SDRAM responder model, pixel scoreboard, directed scenarios.
// Latency: responder returns each accepted read a programmable number of cycles later.
// Backpressure: pix_ready and waitrequest are driven per scenario.
module tb_sdram_frame_reader;

   localparam int          FW    = 8;
   localparam int          DEPTH = 4;
   localparam logic [25:0] BASE  = 26'h0;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        frame_ready = 1'b0;
   logic        waitrequest = 1'b0;
   logic [31:0] SD_rdata = '0;
   logic        SD_readdatavalid = 1'b0;
   logic        pix_ready = 1'b0;
   logic        SD_read;
   logic [25:0] SD_address;
   logic [7:0]  pix_r, pix_g, pix_b;
   logic        pix_valid, busy, frame_done, overflow_err;

   sdram_frame_reader #(
      .BASE_ADDR   (BASE),
      .FRAME_WORDS (FW),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk              (clk),
      .n_rst            (n_rst),
      .frame_ready      (frame_ready),
      .SD_read          (SD_read),
      .SD_address       (SD_address),
      .waitrequest      (waitrequest),
      .SD_rdata         (SD_rdata),
      .SD_readdatavalid (SD_readdatavalid),
      .pix_r            (pix_r),
      .pix_g            (pix_g),
      .pix_b            (pix_b),
      .pix_valid        (pix_valid),
      .pix_ready        (pix_ready),
      .busy             (busy),
      .frame_done       (frame_done),
      .overflow_err     (overflow_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] dat;
   } ret_t;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          lat = 2;
   logic        use_const = 1'b1;
   int          stall_idx = -1;
   int          stall_len = 0;
   int          stall_cnt = 0;
   int          n_stall = 0;
   logic        drop_mode = 1'b0;
   logic        inject = 1'b0;
   logic [25:0] exp_addr = BASE;
   int          n_acc = 0;
   int          n_pop = 0;
   int          n_done = 0;
   int          last_pop_cyc = 0;
   ret_t        ret_q[$];
   logic [23:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // SDRAM responder: accept on negedge view, return after lat cycles, stall on request.
   initial begin
      ret_t        r;
      logic [7:0]  k;
      logic [31:0] d;
      forever begin
         @(negedge clk);
         if (n_rst && SD_read) begin
            check("sd_address", 32'(SD_address), 32'(exp_addr));
            if (waitrequest) begin
               n_stall++;
            end else begin
               k = 8'((exp_addr - BASE) >> 2);
               d = use_const ? 32'h00CCBBAA : {8'hE5, 8'h30 + k, 8'h20 + k, 8'h10 + k};
               ret_q.push_back('{cyc + lat, d});
               n_acc++;
               exp_addr = exp_addr + 26'd4;
               if (exp_addr == BASE + 26'(4 * FW)) exp_addr = BASE;
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         if (inject) begin
            SD_readdatavalid = 1'b1;
            SD_rdata         = 32'hDEADBEEF;
         end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            r = ret_q.pop_front();
            SD_readdatavalid = 1'b1;
            SD_rdata         = r.dat;
            if (!drop_mode) exp_q.push_back({r.dat[23:16], r.dat[15:8], r.dat[7:0]});
         end else begin
            SD_readdatavalid = 1'b0;
         end
         if (SD_read && n_acc == stall_idx && stall_cnt < stall_len) begin
            waitrequest = 1'b1;
            stall_cnt++;
         end else begin
            waitrequest = 1'b0;
         end
      end
   end

   // Pixel monitor and frame_done checks.
   initial begin
      logic [23:0] e;
      forever begin
         @(negedge clk);
         if (frame_done) begin
            n_done++;
            check("done_after_last_pop", 32'(cyc - last_pop_cyc), 32'd1);
            check("scoreboard_empty_at_done", 32'(exp_q.size()), 32'd0);
`ifndef FRAME_READER_LOOP_EN
            check("busy_at_done", 32'(busy), 32'd0);
`endif
         end
         if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL pixel: got %h expected none", {pix_b, pix_g, pix_r});
            end else begin
               e = exp_q.pop_front();
               check("pixel", 32'({pix_b, pix_g, pix_r}), 32'(e));
            end
            n_pop++;
            last_pop_cyc = cyc;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      exp_addr    = BASE;
      n_acc       = 0;
      n_pop       = 0;
      frame_ready = 1'b1;
      @(posedge clk);
      #1;
      frame_ready = 1'b0;
      @(negedge clk);
      check("sd_read_after_start", 32'(SD_read), 32'd1);
      check("busy_after_start", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int target, input int budget);
      int i = 0;
      while (n_done < target && i < budget) begin
         @(posedge clk);
         #1;
         i++;
      end
      check("frame_done_reached", 32'(n_done >= target), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sd_read"}, 32'(SD_read), 32'd0);
      check({tag, "_sd_address"}, 32'(SD_address), 32'(BASE));
      check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
      check({tag, "_pix_rgb"}, 32'({pix_r, pix_g, pix_b}), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      check({tag, "_overflow"}, 32'(overflow_err), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got still running expected finished");
      $fatal(1);
   end

   initial begin
      logic seen_pv;
      tick(3);
      check_reset_outputs("reset");
      n_rst = 1'b1;
      tick(2);

`ifndef FRAME_READER_LOOP_EN
      // Plain frame, constant word, no stalls.
      lat = 2; use_const = 1'b1; pix_ready = 1'b1;
      start_frame();
      wait_done(1, 200);
      tick(5);
      check("t1_done_count", 32'(n_done), 32'd1);
      check("t1_accepts", 32'(n_acc), 32'd8);
      check("t1_pops", 32'(n_pop), 32'd8);
      check("t1_busy_low", 32'(busy), 32'd0);

      // Five-cycle waitrequest on the third request.
      use_const = 1'b0; stall_idx = 2; stall_len = 5; stall_cnt = 0; n_stall = 0;
      start_frame();
      wait_done(2, 200);
      tick(5);
      check("t2_accepts", 32'(n_acc), 32'd8);
      check("t2_pops", 32'(n_pop), 32'd8);
      check("t2_stall_cycles", 32'(n_stall), 32'd5);
      stall_idx = -1;

      // Consumer stalled: credit caps outstanding+buffered at the FIFO depth.
      lat = 3; pix_ready = 1'b0;
      start_frame();
      tick(30);
      check("t3_accepts_capped", 32'(n_acc), 32'(DEPTH));
      check("t3_sd_read_low", 32'(SD_read), 32'd0);
      check("t3_no_overflow", 32'(overflow_err), 32'd0);
      check("t3_pix_valid", 32'(pix_valid), 32'd1);
      pix_ready = 1'b1;
      wait_done(3, 200);
      tick(5);
      check("t3_accepts", 32'(n_acc), 32'd8);
      check("t3_pops", 32'(n_pop), 32'd8);

      // Return forced into a full FIFO by faking an outstanding read.
      lat = 2; pix_ready = 1'b0;
      start_frame();
      tick(20);
      check("t4_pre_overflow", 32'(overflow_err), 32'd0);
      @(negedge clk);
      inject = 1'b1;
      @(posedge clk);
      #2;
      force dut.r_pending = 3'd1;
      inject = 1'b0;
      @(posedge clk);
      #2;
      force dut.r_pending = 3'd0;
      #1;
      release dut.r_pending;
      tick(1);
      check("t4_overflow_set", 32'(overflow_err), 32'd1);
      pix_ready = 1'b1;
      wait_done(4, 200);
      tick(5);
      check("t4_overflow_sticky", 32'(overflow_err), 32'd1);
      check("t4_pops", 32'(n_pop), 32'd8);

      // Reset mid-fetch, then stray returns must not produce pixels.
      lat = 3;
      start_frame();
      tick(3);
      n_rst = 1'b0;
      drop_mode = 1'b1;
      exp_q.delete();
      #1;
      check_reset_outputs("midreset");
      tick(1);
      n_rst = 1'b1;
      seen_pv = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (pix_valid) seen_pv = 1'b1;
      end
      check("t5_no_stray_pixel", 32'(seen_pv), 32'd0);
      check("t5_idle", 32'(busy), 32'd0);
      check("t5_no_done", 32'(n_done), 32'd4);
      drop_mode = 1'b0;
`else
      // Continuous scan-out: two frames from one frame_ready.
      lat = 2; use_const = 1'b0; pix_ready = 1'b1;
      start_frame();
      wait_done(2, 400);
      check("loop_pops", 32'(n_pop), 32'd16);
      check("loop_busy", 32'(busy), 32'd1);
      check("loop_no_overflow", 32'(overflow_err), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
